// File: rtl/vai_c2_rsp_arb_if.sv
// c2 response arbiter bundle: forward/response inputs,
// registered c2 outputs and status.
`timescale 1ns/1ps
interface vai_c2_rsp_arb_if #(
  parameter int TID_WIDTH = 9
);
  logic                 fwd_rd_valid;
  logic [TID_WIDTH-1:0] fwd_rd_tid;
  logic                 mgr_rsp_valid;
  logic [TID_WIDTH-1:0] mgr_rsp_tid;
  logic [63:0]          mgr_rsp_data;
  logic                 afu_rsp_valid;
  logic [TID_WIDTH-1:0] afu_rsp_tid;
  logic [63:0]          afu_rsp_data;
  logic                 c2_valid;
  logic [TID_WIDTH-1:0] c2_tid;
  logic [63:0]          c2_data;
  logic                 pend_full;
  logic [15:0]          timeout_cnt;
  logic [2:0]           err_flags;

  modport master (
    output fwd_rd_valid, fwd_rd_tid,
    output mgr_rsp_valid, mgr_rsp_tid, mgr_rsp_data,
    output afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
    input  c2_valid, c2_tid, c2_data,
    input  pend_full, timeout_cnt, err_flags
  );

  modport slave (
    input  fwd_rd_valid, fwd_rd_tid,
    input  mgr_rsp_valid, mgr_rsp_tid, mgr_rsp_data,
    input  afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
    output c2_valid, c2_tid, c2_data,
    output pend_full, timeout_cnt, err_flags
  );
endinterface

// File: rtl/vai_c2_rsp_arb.sv
// c2 MMIO read response arbiter: merges local and sub-AFU
// responses, tracks forwarded reads, synthesizes timeouts.
`timescale 1ns/1ps
module vai_c2_rsp_arb #(
  parameter int PEND_DEPTH = 16,
  parameter int RSP_DEPTH  = 8,
  parameter int TIMEOUT    = 4096,
  parameter int TID_WIDTH  = 9
) (
  input logic             pClk,
  input logic             Resetb,
  vai_c2_rsp_arb_if.slave bus
);
  localparam int PAW = $clog2(PEND_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int AGW = $clog2(TIMEOUT);
  localparam int RW  = TID_WIDTH + 64;

  typedef enum logic [1:0] {
    P_EMPTY, P_WAIT, P_EXPIRED
  } state_t;

  logic [TID_WIDTH-1:0] r_pend_mem [PEND_DEPTH];
  logic [PAW-1:0]       r_pend_rd, r_pend_wr;
  logic [PAW:0]         r_pend_cnt;
  logic [RW-1:0]        r_rsp_mem [RSP_DEPTH];
  logic [RAW-1:0]       r_rsp_rd, r_rsp_wr;
  logic [RAW:0]         r_rsp_cnt;
  state_t               r_state;
  logic [AGW-1:0]       r_age;
  logic                 r_c2_valid;
  logic [TID_WIDTH-1:0] r_c2_tid;
  logic [63:0]          r_c2_data;
  logic [15:0]          r_to_cnt;
  logic [2:0]           r_err;

  logic                 w_pend_ne, w_pend_full;
  logic                 w_rsp_ne, w_rsp_full;
  logic [TID_WIDTH-1:0] w_pend_head;
  logic [TID_WIDTH-1:0] w_rsp_tid;
  logic [63:0]          w_rsp_data;
  logic                 w_match;
  logic                 w_g_mgr, w_g_afu, w_g_to;
  logic                 w_stray, w_emit;
  logic                 w_pend_push, w_pend_pop;
  logic                 w_pend_ovf;
  logic                 w_rsp_push, w_rsp_pop;
  logic                 w_rsp_ovf;
  logic [PAW:0]         w_pend_cnt_nxt;
  state_t               w_state_nxt;
  logic [AGW-1:0]       w_age_nxt;
  logic [TID_WIDTH-1:0] w_c2_tid;
  logic [63:0]          w_c2_data;

  assign w_pend_ne   = (r_pend_cnt != '0);
  assign w_pend_full = (r_pend_cnt == (PAW+1)'(PEND_DEPTH));
  assign w_rsp_ne    = (r_rsp_cnt != '0);
  assign w_rsp_full  = (r_rsp_cnt == (RAW+1)'(RSP_DEPTH));
  assign w_pend_head = r_pend_mem[r_pend_rd];
  assign w_rsp_tid   = r_rsp_mem[r_rsp_rd][RW-1:64];
  assign w_rsp_data  = r_rsp_mem[r_rsp_rd][63:0];

  // Only the two FIFO heads are compared: replies come back in order.
  assign w_match = w_rsp_ne & w_pend_ne
                 & (w_rsp_tid == w_pend_head);
  assign w_g_mgr = bus.mgr_rsp_valid;
  assign w_g_afu = ~w_g_mgr & w_match;
  assign w_stray = ~w_g_mgr & w_rsp_ne & ~w_match;
  assign w_g_to  = ~w_g_mgr & ~w_match
                 & (r_state == P_EXPIRED);
  assign w_emit  = w_g_mgr | w_g_afu | w_g_to;

  assign w_pend_pop  = w_g_afu | w_g_to;
  assign w_pend_push = bus.fwd_rd_valid
                     & (~w_pend_full | w_pend_pop);
  assign w_pend_ovf  = bus.fwd_rd_valid
                     & w_pend_full & ~w_pend_pop;
  assign w_rsp_pop   = w_g_afu | w_stray;
  assign w_rsp_push  = bus.afu_rsp_valid & ~w_rsp_full;
  assign w_rsp_ovf   = bus.afu_rsp_valid & w_rsp_full;

  assign w_pend_cnt_nxt = r_pend_cnt
                        + (PAW+1)'(w_pend_push)
                        - (PAW+1)'(w_pend_pop);

  // FIFO storage, no reset needed: guarded by counts.
  always_ff @(posedge pClk) begin
    if (w_pend_push)
      r_pend_mem[r_pend_wr] <= bus.fwd_rd_tid;
    if (w_rsp_push)
      r_rsp_mem[r_rsp_wr] <= {bus.afu_rsp_tid,
                              bus.afu_rsp_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pClk or negedge Resetb) begin
    if (!Resetb) begin
      r_pend_rd  <= '0;
      r_pend_wr  <= '0;
      r_pend_cnt <= '0;
      r_rsp_rd   <= '0;
      r_rsp_wr   <= '0;
      r_rsp_cnt  <= '0;
    end else begin
      if (w_pend_push) r_pend_wr <= r_pend_wr + 1'b1;
      if (w_pend_pop)  r_pend_rd <= r_pend_rd + 1'b1;
      r_pend_cnt <= w_pend_cnt_nxt;
      if (w_rsp_push) r_rsp_wr <= r_rsp_wr + 1'b1;
      if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + 1'b1;
      r_rsp_cnt <= r_rsp_cnt
                 + (RAW+1)'(w_rsp_push)
                 - (RAW+1)'(w_rsp_pop);
    end
  end

  // Head FSM state and age register.
  always_ff @(posedge pClk or negedge Resetb) begin
    if (!Resetb) begin
      r_state <= P_EMPTY;
      r_age   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
    end
  end

  // Head FSM: age the head read; expiry lands as age hits TIMEOUT-1.
  always_comb begin
    w_state_nxt = r_state;
    w_age_nxt   = r_age;
    if (w_pend_pop) begin
      w_age_nxt   = '0;
      w_state_nxt = (w_pend_cnt_nxt != '0) ? P_WAIT
                                           : P_EMPTY;
    end else begin
      unique case (r_state)
        P_EMPTY: begin
          if (w_pend_ne) begin
            w_state_nxt = P_WAIT;
            w_age_nxt   = '0;
          end
        end
        P_WAIT: begin
          w_age_nxt = r_age + 1'b1;
          if (r_age == AGW'(TIMEOUT - 2))
            w_state_nxt = P_EXPIRED;
        end
        P_EXPIRED: ;
        default: w_state_nxt = P_EMPTY;
      endcase
    end
  end

  // c2 payload select; the timeout payload is the default.
  always_comb begin
    w_c2_tid  = w_pend_head;
    w_c2_data = '1;
    unique case (1'b1)
      w_g_mgr: begin
        w_c2_tid  = bus.mgr_rsp_tid;
        w_c2_data = bus.mgr_rsp_data;
      end
      w_g_afu: begin
        w_c2_tid  = w_rsp_tid;
        w_c2_data = w_rsp_data;
      end
      default: ;
    endcase
  end

  // Registered c2 outputs, timeout counter and sticky errors.
  always_ff @(posedge pClk or negedge Resetb) begin
    if (!Resetb) begin
      r_c2_valid <= 1'b0;
      r_c2_tid   <= '0;
      r_c2_data  <= '0;
      r_to_cnt   <= '0;
      r_err      <= '0;
    end else begin
      r_c2_valid <= w_emit;
      if (w_emit) begin
        r_c2_tid  <= w_c2_tid;
        r_c2_data <= w_c2_data;
      end
      if (w_g_to && r_to_cnt != 16'hFFFF)
        r_to_cnt <= r_to_cnt + 16'd1;
      r_err <= r_err | {w_stray, w_rsp_ovf, w_pend_ovf};
    end
  end

  assign bus.c2_valid    = r_c2_valid;
  assign bus.c2_tid      = r_c2_tid;
  assign bus.c2_data     = r_c2_data;
  assign bus.pend_full   = w_pend_full;
  assign bus.timeout_cnt = r_to_cnt;
  assign bus.err_flags   = r_err;
endmodule

// File: tb/tb_vai_c2_rsp_arb.sv
// Bench for vai_c2_rsp_arb: directed scenarios plus a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_vai_c2_rsp_arb;
  localparam int TO = 64;
  localparam int PD = 16;
  localparam int RD = 8;

  logic pClk = 1'b0;
  logic Resetb = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  vai_c2_rsp_arb_if #(.TID_WIDTH(9)) bus();

  vai_c2_rsp_arb #(
    .PEND_DEPTH(PD),
    .RSP_DEPTH (RD),
    .TIMEOUT   (TO),
    .TID_WIDTH (9)
  ) dut (
    .pClk  (pClk),
    .Resetb(Resetb),
    .bus   (bus)
  );

  always #5 pClk = ~pClk;

  // Reference model: pending tids and buffered replies as
  // queues; the head read expires TO cycles after it starts
  // being timed (one cycle after entering an empty tracker).
  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  logic [8:0]  pq[$];
  rsp_t        rq[$];
  rsp_t        m_r;
  logic [8:0]  m_p;
  longint      m_now, m_hs;
  int          m_psz, m_rsz;
  bit          m_match, m_exp, m_pop;
  logic        m_valid;
  logic [8:0]  m_tid;
  logic [63:0] m_data;
  logic [15:0] m_tcnt;
  logic [2:0]  m_err;
  logic        m_full;

  initial begin
    forever begin
      @(posedge pClk or negedge Resetb);
      if (!Resetb) begin
        pq.delete();
        rq.delete();
        m_now = 0; m_hs = 0;
        m_valid = 0; m_tid = '0; m_data = '0;
        m_tcnt = '0; m_err = '0; m_full = 0;
      end else begin
        m_psz = pq.size();
        m_rsz = rq.size();
        m_match = m_psz > 0 && m_rsz > 0
                  && rq[0].tid == pq[0];
        m_exp = m_psz > 0 && m_now >= m_hs + TO;
        m_valid = 0;
        m_pop = 0;
        if (bus.mgr_rsp_valid) begin
          m_valid = 1;
          m_tid = bus.mgr_rsp_tid;
          m_data = bus.mgr_rsp_data;
        end else if (m_match) begin
          m_r = rq.pop_front();
          m_p = pq.pop_front();
          m_valid = 1;
          m_tid = m_r.tid;
          m_data = m_r.data;
          m_pop = 1;
        end else begin
          if (m_rsz > 0) begin
            m_r = rq.pop_front();
            m_err[2] = 1;
          end
          if (m_exp) begin
            m_p = pq.pop_front();
            m_valid = 1;
            m_tid = m_p;
            m_data = '1;
            m_pop = 1;
            if (m_tcnt != 16'hFFFF) m_tcnt++;
          end
        end
        if (bus.fwd_rd_valid) begin
          if (m_psz == PD && !m_pop) m_err[0] = 1;
          else pq.push_back(bus.fwd_rd_tid);
        end
        if (bus.afu_rsp_valid) begin
          if (m_rsz == RD) m_err[1] = 1;
          else rq.push_back('{bus.afu_rsp_tid,
                              bus.afu_rsp_data});
        end
        if (m_pop && pq.size() > 0) m_hs = m_now;
        else if (m_psz == 0 && pq.size() > 0)
          m_hs = m_now + 1;
        m_full = pq.size() == PD;
        m_now++;
      end
    end
  end

  task automatic idle_inputs();
    bus.fwd_rd_valid  = 0; bus.fwd_rd_tid  = '0;
    bus.mgr_rsp_valid = 0; bus.mgr_rsp_tid = '0;
    bus.mgr_rsp_data  = '0;
    bus.afu_rsp_valid = 0; bus.afu_rsp_tid = '0;
    bus.afu_rsp_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge pClk);
    idle_inputs();
    Resetb = 0;
    repeat (2) @(negedge pClk);
    Resetb = 1;
    @(negedge pClk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.c2_valid !== 1'b0 || bus.c2_tid !== 9'h0
        || bus.c2_data !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_c2: got v=%b tid=%h data=%h want 0",
               bus.c2_valid, bus.c2_tid, bus.c2_data);
    end
    n_checks++;
    if (bus.pend_full !== 1'b0 || bus.timeout_cnt !== 16'h0
        || bus.err_flags !== 3'b0) begin
      n_errors++;
      $display("FAIL reset_status: full=%b tcnt=%h err=%b want 0",
               bus.pend_full, bus.timeout_cnt, bus.err_flags);
    end
  endtask

  task automatic test_local();
    do_reset();
    bus.mgr_rsp_valid = 1;
    bus.mgr_rsp_tid = 9'h012;
    bus.mgr_rsp_data = 64'hA5;
    @(negedge pClk);
    idle_inputs();
    n_checks++;
    if (bus.c2_valid !== 1'b1 || bus.c2_tid !== 9'h012
        || bus.c2_data !== 64'hA5) begin
      n_errors++;
      $display("FAIL local_rsp: got v=%b tid=%h data=%h want 1/012/a5",
               bus.c2_valid, bus.c2_tid, bus.c2_data);
    end
    @(negedge pClk);
    n_checks++;
    if (bus.c2_valid !== 1'b0 || bus.c2_tid !== 9'h012) begin
      n_errors++;
      $display("FAIL local_single: got v=%b tid=%h want 0/012",
               bus.c2_valid, bus.c2_tid);
    end
  endtask

  task automatic test_fwd_return();
    int seen = 0;
    logic [8:0]  tid = '0;
    logic [63:0] dat = '0;
    do_reset();
    bus.fwd_rd_valid = 1;
    bus.fwd_rd_tid = 9'h040;
    @(negedge pClk);
    idle_inputs();
    repeat (4) @(negedge pClk);
    bus.afu_rsp_valid = 1;
    bus.afu_rsp_tid = 9'h040;
    bus.afu_rsp_data = 64'h1234;
    @(negedge pClk);
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge pClk);
      if (bus.c2_valid) begin
        seen++;
        tid = bus.c2_tid;
        dat = bus.c2_data;
      end
    end
    n_checks++;
    if (seen != 1 || tid !== 9'h040 || dat !== 64'h1234) begin
      n_errors++;
      $display("FAIL fwd_return: pulses=%0d tid=%h data=%h want 1/040/1234",
               seen, tid, dat);
    end
    n_checks++;
    if (bus.timeout_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL fwd_no_timeout: tcnt=%0d want 0",
               bus.timeout_cnt);
    end
  endtask

  task automatic test_timeout();
    int lat = -1;
    int extra = 0;
    do_reset();
    bus.fwd_rd_valid = 1;
    bus.fwd_rd_tid = 9'h041;
    @(negedge pClk);
    idle_inputs();
    for (int n = 1; n <= TO + 10; n++) begin
      if (bus.c2_valid) begin
        lat = n - 1;
        break;
      end
      @(negedge pClk);
    end
    n_checks++;
    if (lat != TO + 1) begin
      n_errors++;
      $display("FAIL timeout_latency: got %0d want %0d",
               lat, TO + 1);
    end
    n_checks++;
    if (bus.c2_tid !== 9'h041 || bus.c2_data !== '1
        || bus.timeout_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL timeout_rsp: tid=%h data=%h tcnt=%0d want 041/ones/1",
               bus.c2_tid, bus.c2_data, bus.timeout_cnt);
    end
    @(negedge pClk);
    bus.afu_rsp_valid = 1;
    bus.afu_rsp_tid = 9'h041;
    bus.afu_rsp_data = 64'h77;
    @(negedge pClk);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge pClk);
      if (bus.c2_valid) extra++;
    end
    n_checks++;
    if (extra != 0 || bus.err_flags !== 3'b100) begin
      n_errors++;
      $display("FAIL late_stray: pulses=%0d err=%b want 0/100",
               extra, bus.err_flags);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.fwd_rd_valid = 1;
    bus.fwd_rd_tid = 9'h050;
    @(negedge pClk);
    idle_inputs();
    repeat (2) @(negedge pClk);
    bus.mgr_rsp_valid = 1;
    bus.mgr_rsp_tid = 9'h077;
    bus.mgr_rsp_data = 64'hBEEF;
    bus.afu_rsp_valid = 1;
    bus.afu_rsp_tid = 9'h050;
    bus.afu_rsp_data = 64'h5050;
    @(negedge pClk);
    idle_inputs();
    n_checks++;
    if (bus.c2_valid !== 1'b1 || bus.c2_tid !== 9'h077
        || bus.c2_data !== 64'hBEEF) begin
      n_errors++;
      $display("FAIL collide_mgr: v=%b tid=%h data=%h want 1/077/beef",
               bus.c2_valid, bus.c2_tid, bus.c2_data);
    end
    @(negedge pClk);
    n_checks++;
    if (bus.c2_valid !== 1'b1 || bus.c2_tid !== 9'h050
        || bus.c2_data !== 64'h5050) begin
      n_errors++;
      $display("FAIL collide_afu: v=%b tid=%h data=%h want 1/050/5050",
               bus.c2_valid, bus.c2_tid, bus.c2_data);
    end
  endtask

  task automatic test_full();
    int got = 0;
    int bad = 0;
    bit first = 1;
    do_reset();
    for (int i = 0; i < PD; i++) begin
      bus.fwd_rd_valid = 1;
      bus.fwd_rd_tid = 9'(9'h100 + i);
      @(negedge pClk);
    end
    idle_inputs();
    n_checks++;
    if (bus.pend_full !== 1'b1 || bus.err_flags !== 3'b0) begin
      n_errors++;
      $display("FAIL full_set: full=%b err=%b want 1/000",
               bus.pend_full, bus.err_flags);
    end
    bus.fwd_rd_valid = 1;
    bus.fwd_rd_tid = 9'h1FF;
    @(negedge pClk);
    idle_inputs();
    n_checks++;
    if (bus.err_flags !== 3'b001 || bus.pend_full !== 1'b1) begin
      n_errors++;
      $display("FAIL full_overflow: err=%b full=%b want 001/1",
               bus.err_flags, bus.pend_full);
    end
    for (int c = 0; c < 40; c++) begin
      if (c < PD) begin
        bus.afu_rsp_valid = 1;
        bus.afu_rsp_tid = 9'(9'h100 + c);
        bus.afu_rsp_data = 64'(c + 1);
      end else idle_inputs();
      @(negedge pClk);
      if (bus.c2_valid) begin
        if (first && bus.pend_full !== 1'b0) bad++;
        first = 0;
        if (bus.c2_tid !== 9'(9'h100 + got)
            || bus.c2_data !== 64'(got + 1)) bad++;
        got++;
      end
    end
    idle_inputs();
    n_checks++;
    if (got != PD || bad != 0 || bus.timeout_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL full_drain: pulses=%0d bad=%0d tcnt=%0d want %0d/0/0",
               got, bad, bus.timeout_cnt, PD);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    do_reset();
    bus.mgr_rsp_valid = 1;
    bus.mgr_rsp_tid = 9'h0AB;
    bus.mgr_rsp_data = 64'hDEAD;
    @(negedge pClk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.fwd_rd_valid = 1;
      bus.fwd_rd_tid = 9'(9'h60 + i);
      @(negedge pClk);
    end
    idle_inputs();
    #2 Resetb = 0;
    #1;
    n_checks++;
    if (bus.c2_tid !== 9'h0 || bus.c2_data !== 64'h0
        || bus.c2_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: tid=%h data=%h v=%b want 0",
               bus.c2_tid, bus.c2_data, bus.c2_valid);
    end
    @(negedge pClk);
    Resetb = 1;
    for (int i = 0; i < 2 * TO + 10; i++) begin
      @(negedge pClk);
      if (bus.c2_valid) extra++;
    end
    n_checks++;
    if (extra != 0 || bus.timeout_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_lost: pulses=%0d tcnt=%0d want 0/0",
               extra, bus.timeout_cnt);
    end
  endtask

  task automatic test_random();
    logic [8:0] gq[$];
    logic [8:0] t;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      n_checks++;
      if (bus.c2_valid !== m_valid || bus.c2_tid !== m_tid
          || bus.c2_data !== m_data) begin
        n_errors++;
        $display("FAIL rand_c2 @%0d: got %b/%h/%h want %b/%h/%h",
                 c, bus.c2_valid, bus.c2_tid, bus.c2_data,
                 m_valid, m_tid, m_data);
      end
      n_checks++;
      if (bus.pend_full !== m_full || bus.timeout_cnt !== m_tcnt
          || bus.err_flags !== m_err) begin
        n_errors++;
        $display("FAIL rand_status @%0d: got %b/%0d/%b want %b/%0d/%b",
                 c, bus.pend_full, bus.timeout_cnt, bus.err_flags,
                 m_full, m_tcnt, m_err);
      end
      idle_inputs();
      if ($urandom_range(0, 5) == 0) begin
        t = 9'($urandom_range(0, 511));
        bus.fwd_rd_valid = 1;
        bus.fwd_rd_tid = t;
        gq.push_back(t);
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.mgr_rsp_valid = 1;
        bus.mgr_rsp_tid = 9'($urandom_range(0, 511));
        bus.mgr_rsp_data = {$urandom, $urandom};
      end
      if ($urandom_range(0, 63) == 0) begin
        bus.afu_rsp_valid = 1;
        bus.afu_rsp_tid = 9'($urandom_range(0, 511));
        bus.afu_rsp_data = {$urandom, $urandom};
      end else if (gq.size() > 0
                   && $urandom_range(0, 3) == 0) begin
        t = gq.pop_front();
        if ($urandom_range(0, 15) != 0) begin
          bus.afu_rsp_valid = 1;
          bus.afu_rsp_tid = t;
          bus.afu_rsp_data = {$urandom, $urandom};
        end
      end
      @(negedge pClk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_local();
    test_fwd_return();
    test_timeout();
    test_collision();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
